// File: rtl/eeprom_rw_test.sv
// EEPROM self-test sequencer: writes an incrementing XOR-A5 pattern through a byte-level
// I2C master, reads it back, and reports completion and pass/fail.
module eeprom_rw_test #(
    parameter int          CLOCK_FREQ   = 50000000,
    parameter int          START_DLY_US = 1000,
    parameter int          TWR_US       = 5000,
    parameter int          BYTE_NUM     = 16,
    parameter logic [15:0] BASE_ADDR    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        i2c_exec,
    output logic        i2c_rh_wl,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data_w,
    input  logic        i2c_done,
    input  logic        i2c_ack_err,
    input  logic [7:0]  i2c_data_r,
    output logic        rw_done,
    output logic        rw_res
);

    localparam logic [31:0] START_TICKS = 32'(CLOCK_FREQ / 1000000 * START_DLY_US - 1);
    localparam logic [31:0] TWR_TICKS   = 32'(CLOCK_FREQ / 1000000 * TWR_US - 1);
    localparam logic [8:0]  LAST_IDX    = 9'(BYTE_NUM - 1);

    typedef enum logic [2:0] {
        S_START, S_WR_REQ, S_WR_WAIT, S_TWR, S_RD_REQ, S_RD_WAIT, S_PASS, S_FAIL
    } state_t;

    state_t      state, next_state;
    logic [31:0] cnt;
    logic [8:0]  idx;
    logic [7:0]  pattern;
    logic        start_end, twr_end, done_v, last, match;
    logic        exec_d, done_d, res_d;

    assign start_end = (cnt == START_TICKS);
    assign twr_end   = (cnt == TWR_TICKS);
    // A done coinciding with our own exec pulse belongs to an abandoned transaction
    assign done_v    = i2c_done & ~i2c_exec;
    assign last      = (idx == LAST_IDX);
    assign pattern   = idx[7:0] ^ 8'hA5;
    assign match     = (i2c_data_r == pattern);

    always_ff @(posedge clk) begin
        if (rst) state <= S_START;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            if ((state == S_START && !start_end) || (state == S_TWR && !twr_end))
                cnt <= cnt + 32'd1;
            else
                cnt <= '0;
            if (state == S_TWR && twr_end)
                idx <= last ? 9'd0 : idx + 9'd1;
            else if (state == S_RD_WAIT && done_v && !i2c_ack_err && match && !last)
                idx <= idx + 9'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_START:   if (start_end) next_state = S_WR_REQ;
            S_WR_REQ:  next_state = S_WR_WAIT;
            S_WR_WAIT: if (done_v) next_state = i2c_ack_err ? S_FAIL : S_TWR;
            S_TWR:     if (twr_end) next_state = last ? S_RD_REQ : S_WR_REQ;
            S_RD_REQ:  next_state = S_RD_WAIT;
            S_RD_WAIT: if (done_v) begin
                           if (i2c_ack_err || !match) next_state = S_FAIL;
                           else if (last)             next_state = S_PASS;
                           else                       next_state = S_RD_REQ;
                       end
            S_PASS:    next_state = S_PASS;
            S_FAIL:    next_state = S_FAIL;
            default:   next_state = S_START;
        endcase
    end

    always_comb begin
        exec_d = (state == S_WR_REQ) || (state == S_RD_REQ);
        done_d = (next_state == S_PASS) || (next_state == S_FAIL);
        res_d  = (next_state == S_PASS);
    end

    // Command fields are loaded with the exec pulse and held until the next request
    always_ff @(posedge clk) begin
        if (rst) begin
            i2c_exec   <= 1'b0;
            i2c_rh_wl  <= 1'b0;
            i2c_addr   <= '0;
            i2c_data_w <= '0;
            rw_done    <= 1'b0;
            rw_res     <= 1'b0;
        end else begin
            i2c_exec <= exec_d;
            rw_done  <= done_d;
            rw_res   <= res_d;
            if (exec_d) begin
                i2c_rh_wl <= (state == S_RD_REQ);
                i2c_addr  <= BASE_ADDR + {7'd0, idx};
            end
            if (state == S_WR_REQ) i2c_data_w <= pattern;
        end
    end

endmodule
